// File: rtl/snake_head_ctrl.sv
// snake_head_ctrl: snake head FSM that computes the next cell, checks for collisions, commits the move and tracks length.
module snake_head_ctrl #(
  parameter int MAX_LEN   = 128,
  parameter int START_LEN = 3
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       start,
  input  logic       tick,
  input  logic [1:0] dir_req,
  input  logic       dir_valid,
  input  logic [7:0] food_cell,
  input  logic       probe_occupied,
  output logic [7:0] probe_cell,
  output logic [7:0] head_cell,
  output logic       head_wr,
  output logic       tail_rd,
  output logic [7:0] length,
  output logic       ate,
  output logic       dead
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_CALC   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_DEAD   = 3'd5;
  localparam logic [7:0] L_MAX    = 8'(MAX_LEN);
  localparam logic [7:0] L_START  = 8'(START_LEN);

  logic [2:0] r_st;
  logic [7:0] r_head, r_probe, r_len;
  logic [1:0] r_cur_dir, r_pend_dir, r_mv_dir;
  logic       r_head_wr, r_tail_rd, r_ate;
  logic [3:0] w_x, w_y;
  logic [7:0] w_next;
  logic       w_oob, w_eat, w_grow;

  always_comb begin
    w_x    = r_head[3:0];
    w_y    = r_head[7:4];
    w_next = (r_pend_dir == 2'b00) ? {w_y - 4'd1, w_x} :
             (r_pend_dir == 2'b01) ? {w_y, w_x + 4'd1} :
             (r_pend_dir == 2'b10) ? {w_y + 4'd1, w_x} : {w_y, w_x - 4'd1};
    w_oob  = (r_pend_dir == 2'b00) ? (w_y == 4'd0)  :
             (r_pend_dir == 2'b01) ? (w_x == 4'd15) :
             (r_pend_dir == 2'b10) ? (w_y == 4'd15) : (w_x == 4'd0);
    w_eat  = (r_probe == food_cell);
    w_grow = w_eat && (r_len < L_MAX);
  end

  // r_mv_dir remembers the direction actually used, since pend_dir may change between CALC and commit
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_st       <= S_IDLE;
      r_head     <= 8'h02;
      r_probe    <= 8'h02;
      r_len      <= L_START;
      r_cur_dir  <= 2'b01;
      r_pend_dir <= 2'b01;
      r_mv_dir   <= 2'b01;
      r_head_wr  <= 1'b0;
      r_tail_rd  <= 1'b0;
      r_ate      <= 1'b0;
    end else begin
      r_head_wr <= 1'b0;
      r_tail_rd <= 1'b0;
      r_ate     <= 1'b0;
      if (dir_valid && r_st != S_DEAD && dir_req != (r_cur_dir ^ 2'b10))
        r_pend_dir <= dir_req;
      case (r_st)
        S_IDLE:  r_st <= start ? S_RUN : S_IDLE;
        S_RUN:   r_st <= tick ? S_CALC : S_RUN;
        S_CALC: begin
          r_probe  <= w_next;
          r_mv_dir <= r_pend_dir;
          r_st     <= w_oob ? S_DEAD : S_CHECK;
        end
        S_CHECK: begin
          if (probe_occupied) r_st <= S_DEAD;
          else begin
            r_st      <= S_COMMIT;
            r_head    <= r_probe;
            r_cur_dir <= r_mv_dir;
            r_head_wr <= 1'b1;
            r_ate     <= w_eat;
            r_tail_rd <= !w_grow;
            if (w_grow) r_len <= r_len + 8'd1;
          end
        end
        S_COMMIT: r_st <= S_RUN;
        default:  r_st <= S_DEAD;
      endcase
    end
  end

  assign probe_cell = r_probe;
  assign head_cell  = r_head;
  assign head_wr    = r_head_wr;
  assign tail_rd    = r_tail_rd;
  assign length     = r_len;
  assign ate        = r_ate;
  assign dead       = (r_st == S_DEAD);
endmodule

// File: tb/tb_snake_head_ctrl.sv
// tb_snake_head_ctrl: directed checks of moves, eating, direction filtering, death and async reset.
module tb_snake_head_ctrl;
  logic       clk = 1'b0;
  logic       aclr, start, tick, dir_valid, probe_occupied;
  logic [1:0] dir_req;
  logic [7:0] food_cell, probe_cell, head_cell, length;
  logic       head_wr, tail_rd, ate, dead;
  int         n_cmp = 0;
  int         n_err = 0;

  snake_head_ctrl #(.MAX_LEN(5), .START_LEN(3)) dut (
    .clk(clk), .aclr(aclr), .start(start), .tick(tick), .dir_req(dir_req),
    .dir_valid(dir_valid), .food_cell(food_cell), .probe_occupied(probe_occupied),
    .probe_cell(probe_cell), .head_cell(head_cell), .head_wr(head_wr),
    .tail_rd(tail_rd), .length(length), .ate(ate), .dead(dead)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ends in the COMMIT cycle (or DEAD) with the move's outputs visible
  task automatic mv(input logic occ);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    probe_occupied = occ;
    cyc(1);
    probe_occupied = 1'b0;
  endtask

  task automatic dir(input logic [1:0] d);
    dir_req = d;
    dir_valid = 1'b1;
    cyc(1);
    dir_valid = 1'b0;
  endtask

  task automatic rst_go;
    aclr = 1'b1;
    cyc(1);
    aclr = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    aclr = 1'b1; start = 1'b0; tick = 1'b0; dir_valid = 1'b0; dir_req = 2'b00;
    probe_occupied = 1'b0; food_cell = 8'h88;
    #1;
    chk("rst_head", head_cell, 8'h02);
    chk("rst_probe", probe_cell, 8'h02);
    chk("rst_len", length, 8'd3);
    chk("rst_pulses", {5'd0, head_wr, tail_rd, ate}, 8'd0);
    chk("rst_dead", {7'd0, dead}, 8'd0);
    cyc(2);
    aclr = 1'b0;
    cyc(1);
    chk("post_rst_pulse", {6'd0, head_wr, tail_rd}, 8'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("calc_no_wr", {7'd0, head_wr}, 8'd0);
    cyc(1);
    chk("check_probe", probe_cell, 8'h03);
    chk("check_no_wr", {7'd0, head_wr}, 8'd0);
    cyc(1);
    chk("m1_pulses", {5'd0, head_wr, tail_rd, ate}, 8'b110);
    chk("m1_head", head_cell, 8'h03);
    chk("m1_len", length, 8'd3);
    cyc(1);
    chk("m1_after", {6'd0, head_wr, tail_rd}, 8'd0);
    food_cell = 8'h04;
    mv(1'b0);
    chk("eat_pulses", {5'd0, head_wr, tail_rd, ate}, 8'b101);
    chk("eat_len", length, 8'd4);
    chk("eat_head", head_cell, 8'h04);
    cyc(1);
    food_cell = 8'h88;
    dir(2'b11);
    mv(1'b0);
    chk("rev_dropped", head_cell, 8'h05);
    cyc(1);
    dir(2'b10);
    mv(1'b0);
    chk("down", head_cell, 8'h15);
    cyc(1);
    dir(2'b01);
    mv(1'b0);
    chk("right", head_cell, 8'h16);
    cyc(1);
    dir(2'b00);
    dir(2'b11);
    mv(1'b0);
    chk("up_not_left", head_cell, 8'h06);
    cyc(1);
    dir(2'b01);
    food_cell = 8'h07;
    mv(1'b0);
    chk("grow5_len", length, 8'd5);
    chk("grow5_pulses", {5'd0, head_wr, tail_rd, ate}, 8'b101);
    cyc(1);
    food_cell = 8'h08;
    mv(1'b0);
    chk("sat_pulses", {5'd0, head_wr, tail_rd, ate}, 8'b111);
    chk("sat_len", length, 8'd5);
    chk("sat_head", head_cell, 8'h08);
    cyc(1);
    food_cell = 8'h88;
    mv(1'b1);
    chk("occ_dead", {7'd0, dead}, 8'd1);
    chk("occ_pulses", {5'd0, head_wr, tail_rd, ate}, 8'd0);
    tick = 1'b1; start = 1'b1; dir_req = 2'b10; dir_valid = 1'b1;
    cyc(4);
    tick = 1'b0; start = 1'b0; dir_valid = 1'b0;
    chk("dead_hold", {7'd0, dead}, 8'd1);
    chk("dead_head", head_cell, 8'h08);
    chk("dead_len", length, 8'd5);
    rst_go();
    for (int i = 0; i < 13; i++) begin
      mv(1'b0);
      cyc(1);
    end
    chk("edge_head", head_cell, 8'h0F);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    chk("oob_dead", {7'd0, dead}, 8'd1);
    chk("oob_no_wr", {6'd0, head_wr, tail_rd}, 8'd0);
    tick = 1'b1; start = 1'b1;
    cyc(3);
    tick = 1'b0; start = 1'b0;
    chk("oob_hold", {7'd0, dead}, 8'd1);
    chk("oob_head", head_cell, 8'h0F);
    chk("oob_len", length, 8'd3);
    rst_go();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    aclr = 1'b1;
    #1;
    chk("mid_rst_head", head_cell, 8'h02);
    chk("mid_rst_probe", probe_cell, 8'h02);
    chk("mid_rst_len", length, 8'd3);
    chk("mid_rst_flags", {4'd0, head_wr, tail_rd, ate, dead}, 8'd0);
    cyc(1);
    aclr = 1'b0;
    cyc(1);
    chk("mid_rst_quiet", {6'd0, head_wr, tail_rd}, 8'd0);
    chk("mid_rst_idle", head_cell, 8'h02);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
